// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises instruction fetches and data reads/writes onto one single-ported RAM.
// Latency: RAM strobe one cycle after the request is seen in IDLE; hit one cycle after ram_ready.
// Backpressure: requesters hold their level strobes until the hit; data has priority over fetches.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              CLK,
  input  logic              nRST,
  // instruction side
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [DATA_W-1:0] iload,
  output logic              iHit,
  // data side
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic [DATA_W-1:0] dload,
  output logic              dHit,
  // RAM side
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic              ram_ready,
  // status
  output logic              busy,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DACC  = 3'd1,
    IACC  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t state;
  state_t state_n;

  // Access context captured when leaving IDLE; it drives the RAM for the whole access,
  // including a drain after the requester has walked away.
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] store_q;
  logic              wr_q;
  logic              instr_q;

  logic [CNT_W-1:0]  cnt;
  logic              err_q;
  logic              busy_q;
  logic [DATA_W-1:0] iload_q;
  logic [DATA_W-1:0] dload_q;

  // Control strobes produced by the next-state logic for the datapath registers.
  logic sel_data;
  logic latch;
  logic cnt_clr;
  logic cnt_inc;
  logic set_err;
  logic cap_i;
  logic cap_d;
  logic timeout_hit;

  // Any data strobe wins arbitration; dWEN alone decides read vs write.
  assign sel_data    = dREN | dWEN;
  // The wait that would bring the counter to TIMEOUT is the last one allowed.
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  // State register; an asynchronous reset abandons any RAM access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state and output decode: arbitration, completion, abort, drain and timeout.
  always_comb begin
    state_n = state;
    latch   = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    set_err = 1'b0;
    cap_i   = 1'b0;
    cap_d   = 1'b0;
    ramREN  = 1'b0;
    ramWEN  = 1'b0;
    iHit    = 1'b0;
    dHit    = 1'b0;

    unique case (state)
      IDLE: begin
        // ram_ready here belongs to no access and is ignored.
        if (sel_data) begin
          state_n = DACC;
          latch   = 1'b1;
          cnt_clr = 1'b1;
        end else if (iREN) begin
          state_n = IACC;
          latch   = 1'b1;
          cnt_clr = 1'b1;
        end
      end

      DACC: begin
        ramWEN = wr_q;
        ramREN = !wr_q;
        // Completion beats both abort and timeout when they coincide.
        if (ram_ready) begin
          state_n = RESP;
          cap_d   = !wr_q;
        end else if (timeout_hit) begin
          state_n = IDLE;
          set_err = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          if (!dREN && !dWEN) begin
            state_n = DRAIN;
          end
        end
      end

      IACC: begin
        ramREN = 1'b1;
        if (ram_ready) begin
          state_n = RESP;
          cap_i   = 1'b1;
        end else if (timeout_hit) begin
          state_n = IDLE;
          set_err = 1'b1;
        end else begin
          cnt_inc = 1'b1;
          if (!iREN) begin
            state_n = DRAIN;
          end
        end
      end

      DRAIN: begin
        // The RAM cannot cancel an access: keep presenting it until it finishes,
        // but discard the returned data.
        ramWEN = wr_q;
        ramREN = !wr_q;
        if (ram_ready) begin
          state_n = IDLE;
        end else if (timeout_hit) begin
          state_n = IDLE;
          set_err = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end

      RESP: begin
        // Requester strobes are still high while it samples the hit, so they are
        // not looked at here; arbitration resumes in the following IDLE cycle.
        iHit    = instr_q;
        dHit    = !instr_q;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Access context capture at arbitration time.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q  <= '0;
      store_q <= '0;
      wr_q    <= 1'b0;
      instr_q <= 1'b0;
    end else if (latch) begin
      if (sel_data) begin
        addr_q  <= daddr;
        store_q <= dstore;
        wr_q    <= dWEN;
        instr_q <= 1'b0;
      end else begin
        addr_q  <= iaddr;
        wr_q    <= 1'b0;
        instr_q <= 1'b1;
      end
    end
  end

  // Wait-state counter: restarts per access and keeps counting through a drain.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      err_q <= 1'b0;
    end else if (set_err) begin
      err_q <= 1'b1;
    end
  end

  // Load-data registers; each holds until its own next completed read.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      iload_q <= '0;
      dload_q <= '0;
    end else begin
      if (cap_i) begin
        iload_q <= ramload;
      end
      if (cap_d) begin
        dload_q <= ramload;
      end
    end
  end

  // Registered busy indication tracking the state the FSM is entering.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      busy_q <= 1'b0;
    end else begin
      busy_q <= (state_n != IDLE);
    end
  end

  assign ramaddr     = addr_q;
  assign ramstore    = store_q;
  assign iload       = iload_q;
  assign dload       = dload_q;
  assign busy        = busy_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven and randomized episodes against a transaction-level model.
// Each episode starts in IDLE; the model predicts strobe window, hit cycle and timeout.
// Hand-written sequences cover arbitration order, hit-hold and asynchronous reset.
module tb_mem_arbiter;

  localparam int T = 8;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iHit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dHit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ram_ready;
  logic        busy;
  logic        timeout_err;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iHit(iHit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dHit(dHit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ram_ready(ram_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // Reference state carried across episodes.
  logic [31:0] iload_m = '0;
  logic [31:0] dload_m = '0;
  bit          err_m   = 1'b0;

  // req: 0 = instruction read, 1 = data read, 2 = data write, 3 = dREN+dWEN.
  // k: cycle of ram_ready; a: cycle the requester drops its strobe (0 = never early).
  typedef struct {
    int          req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          k;
    int          a;
    bit          noise;
    int          exp_hit;
    int          exp_last;
    bit          exp_to;
  } ep_t;

  ep_t tbl[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic ep_t mk(input int req, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int k, input int a,
                             input int hit, input int last, input bit to);
    ep_t e;
    e.req = req; e.addr = addr; e.wdata = wdata; e.rdata = rdata;
    e.k = k; e.a = a; e.noise = 1'b0;
    e.exp_hit = hit; e.exp_last = last; e.exp_to = to;
    return e;
  endfunction

  // Outcome from the rules: the access waits at most T cycles; it completes unless the
  // requester left strictly before ram_ready; completion shows one cycle after ram_ready.
  function automatic ep_t predict(input ep_t e);
    ep_t r;
    r = e;
    if (e.k > T) begin
      r.exp_last = T;
      r.exp_hit  = 0;
      r.exp_to   = 1'b1;
    end else begin
      r.exp_last = e.k;
      r.exp_to   = 1'b0;
      r.exp_hit  = (e.a != 0 && e.a < e.k) ? 0 : e.k + 1;
    end
    return r;
  endfunction

  task automatic drive_req(input int req, input bit on, input logic [31:0] addr, input logic [31:0] wdata);
    iREN = on && (req == 0);
    dREN = on && (req == 1 || req == 3);
    dWEN = on && (req >= 2);
    if (req == 0) begin
      iaddr = addr;
      daddr = $urandom;
    end else begin
      daddr = addr;
      iaddr = $urandom;
    end
    dstore = wdata;
  endtask

  // Called #1 after a rising edge with the DUT in IDLE; returns the same way.
  task automatic run_ep(input ep_t e, input string tag);
    bit wr;
    bit ins;
    bit strobe;
    int fin;
    int drop;
    int busy_end;
    wr       = (e.req >= 2);
    ins      = (e.req == 0);
    fin      = (e.exp_hit != 0) ? e.exp_hit + 1 : e.exp_last + 1;
    drop     = (e.a != 0) ? e.a : fin;
    busy_end = (e.exp_hit != 0) ? e.exp_hit : e.exp_last;
    for (int c = 0; c <= fin; c++) begin
      drive_req(e.req, c < drop, e.addr, e.wdata);
      ram_ready = (c == e.k) || (e.noise && (c == 0 || (e.exp_hit != 0 && c == e.exp_hit)));
      ramload   = (c == e.k) ? e.rdata : $urandom;
      @(negedge CLK);
      strobe = (c >= 1) && (c <= e.exp_last);
      if (e.exp_hit != 0 && c == e.exp_hit && !wr) begin
        if (ins) iload_m = e.rdata;
        else     dload_m = e.rdata;
      end
      if (e.exp_to && c == e.exp_last + 1) err_m = 1'b1;
      chk($sformatf("%s c%0d ramREN", tag, c), ramREN, strobe && !wr);
      chk($sformatf("%s c%0d ramWEN", tag, c), ramWEN, strobe && wr);
      if (strobe) chk($sformatf("%s c%0d ramaddr", tag, c), ramaddr, e.addr);
      if (strobe && wr) chk($sformatf("%s c%0d ramstore", tag, c), ramstore, e.wdata);
      chk($sformatf("%s c%0d busy", tag, c), busy, (c >= 1) && (c <= busy_end));
      chk($sformatf("%s c%0d iHit", tag, c), iHit, (e.exp_hit != 0) && (c == e.exp_hit) && ins);
      chk($sformatf("%s c%0d dHit", tag, c), dHit, (e.exp_hit != 0) && (c == e.exp_hit) && !ins);
      chk($sformatf("%s c%0d iload", tag, c), iload, iload_m);
      chk($sformatf("%s c%0d dload", tag, c), dload, dload_m);
      chk($sformatf("%s c%0d timeout_err", tag, c), timeout_err, err_m);
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    ep_t e;
    nRST = 1'b0; iREN = 0; dREN = 0; dWEN = 0; iaddr = 0; daddr = 0; dstore = 0;
    ramload = 0; ram_ready = 0;

    // ---- reset state ----
    #3;
    chk("rst ramREN", ramREN, 0);
    chk("rst ramWEN", ramWEN, 0);
    chk("rst ramaddr", ramaddr, 0);
    chk("rst ramstore", ramstore, 0);
    chk("rst busy", busy, 0);
    chk("rst iHit", iHit, 0);
    chk("rst dHit", dHit, 0);
    chk("rst iload", iload, 0);
    chk("rst dload", dload, 0);
    chk("rst timeout_err", timeout_err, 0);
    #9 nRST = 1'b1;
    @(posedge CLK);
    #1;

    // ---- table-driven episodes with hand-derived expectations ----
    //             req addr          wdata         rdata         k   a  hit last to
    tbl[0] = mk(1, 32'h40,  32'h0,    32'hDEADBEEF,  3, 0,  4, 3, 0); // basic data read
    tbl[1] = mk(0, 32'h100, 32'h0,    32'h11111111,  4, 2,  0, 4, 0); // fetch abort, drain
    tbl[2] = mk(1, 32'h200, 32'h0,    32'h22222222, 20, 0,  0, 8, 1); // timeout
    tbl[3] = mk(1, 32'h44,  32'h0,    32'h5555AAAA,  2, 0,  3, 2, 0); // served after timeout
    tbl[4] = mk(2, 32'h80,  32'h1234, 32'h99999999,  1, 0,  2, 1, 0); // write, dload holds
    tbl[5] = mk(3, 32'h84,  32'hA5A5, 32'h77777777,  2, 0,  3, 2, 0); // dREN+dWEN is a write
    tbl[6] = mk(0, 32'h10,  32'h0,    32'h00000013,  1, 1,  2, 1, 0); // abort with ready
    tbl[7] = mk(1, 32'h48,  32'h0,    32'h0BADF00D,  8, 0,  9, 8, 0); // ready on last wait
    tbl[8] = mk(0, 32'h14,  32'h0,    32'h33333333,  9, 0,  0, 8, 1); // ready one late
    tbl[9] = mk(2, 32'h88,  32'hBEEF, 32'h44444444,  5, 2,  0, 5, 0); // aborted write
    foreach (tbl[i]) run_ep(tbl[i], $sformatf("tbl%0d", i));

    // ---- simultaneous dWEN and iREN: write first, then fetch ----
    iREN = 1; iaddr = 32'h0; dWEN = 1; dREN = 0; daddr = 32'h80; dstore = 32'h1234;
    ram_ready = 0; ramload = 32'h0;
    @(posedge CLK); #1;                       // cycle 1
    ram_ready = 1; ramload = 32'h5A5A5A5A;
    @(negedge CLK);
    chk("sim c1 ramWEN", ramWEN, 1);
    chk("sim c1 ramREN", ramREN, 0);
    chk("sim c1 ramaddr", ramaddr, 32'h80);
    chk("sim c1 ramstore", ramstore, 32'h1234);
    @(posedge CLK); #1;                       // cycle 2
    ram_ready = 0;
    @(negedge CLK);
    chk("sim c2 dHit", dHit, 1);
    chk("sim c2 iHit", iHit, 0);
    chk("sim c2 ramREN", ramREN, 0);
    chk("sim c2 dload", dload, dload_m);
    @(posedge CLK); #1;                       // cycle 3 (IDLE)
    dWEN = 0;
    @(negedge CLK);
    chk("sim c3 busy", busy, 0);
    @(posedge CLK); #1;                       // cycle 4
    ram_ready = 1; ramload = 32'hCAFE0001;
    @(negedge CLK);
    chk("sim c4 ramREN", ramREN, 1);
    chk("sim c4 ramaddr", ramaddr, 32'h0);
    chk("sim c4 dHit", dHit, 0);
    @(posedge CLK); #1;                       // cycle 5
    ram_ready = 0;
    iload_m = 32'hCAFE0001;
    @(negedge CLK);
    chk("sim c5 iHit", iHit, 1);
    chk("sim c5 dHit", dHit, 0);
    chk("sim c5 iload", iload, iload_m);
    @(posedge CLK); #1;
    iREN = 0;
    @(posedge CLK); #1;

    // ---- hit-hold: dREN never dropped ----
    dREN = 1; daddr = 32'h300; ram_ready = 0;
    @(posedge CLK); #1;                       // cycle 1
    ram_ready = 1; ramload = 32'h600D0001;
    @(posedge CLK); #1;                       // cycle 2 RESP
    ram_ready = 0;
    dload_m = 32'h600D0001;
    @(negedge CLK);
    chk("hold c2 dHit", dHit, 1);
    chk("hold c2 ramREN", ramREN, 0);
    chk("hold c2 dload", dload, dload_m);
    @(posedge CLK); #1;                       // cycle 3 IDLE
    @(negedge CLK);
    chk("hold c3 ramREN", ramREN, 0);
    chk("hold c3 busy", busy, 0);
    chk("hold c3 dHit", dHit, 0);
    @(posedge CLK); #1;                       // cycle 4 new access
    ram_ready = 1; ramload = 32'h600D0002;
    @(negedge CLK);
    chk("hold c4 ramREN", ramREN, 1);
    @(posedge CLK); #1;                       // cycle 5
    ram_ready = 0; dREN = 0;
    dload_m = 32'h600D0002;
    @(negedge CLK);
    chk("hold c5 dHit", dHit, 1);
    chk("hold c5 dload", dload, dload_m);
    @(posedge CLK); #1;

    // ---- randomized episodes against the model ----
    for (int n = 0; n < 60; n++) begin
      e.req   = $urandom_range(0, 3);
      e.addr  = $urandom;
      e.wdata = $urandom;
      e.rdata = $urandom;
      e.k     = $urandom_range(1, 10);
      e.a     = 0;
      if ($urandom_range(0, 2) == 0) e.a = $urandom_range(1, (e.k < T) ? e.k : T);
      e.noise = $urandom_range(0, 1);
      e = predict(e);
      run_ep(e, $sformatf("rnd%0d", n));
    end

    // ---- reset in the middle of an access ----
    chk("pre-rst timeout_err", timeout_err, 1);
    dREN = 1; daddr = 32'h400;
    @(posedge CLK); #1;
    chk("mid ramREN before", ramREN, 1);
    chk("mid busy before", busy, 1);
    #2 nRST = 1'b0;
    #1;
    chk("mid ramREN async", ramREN, 0);
    chk("mid ramWEN async", ramWEN, 0);
    chk("mid busy async", busy, 0);
    chk("mid timeout_err async", timeout_err, 0);
    dREN = 0;
    @(negedge CLK);
    nRST = 1'b1;
    iload_m = '0; dload_m = '0; err_m = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("post busy", busy, 0);
    chk("post ramREN", ramREN, 0);
    chk("post iHit", iHit, 0);
    chk("post dHit", dHit, 0);
    chk("post timeout_err", timeout_err, err_m);
    chk("post dload", dload, dload_m);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sits directly downstream of the request unit.
- Takes the instruction-read strobe (iREN) and the data-read/write strobes (dREN, dWEN) and serialises them onto one single-ported RAM interface.
- Returns a one-cycle hit pulse (iHit/dHit) with load data to the requester.
- Handles RAM wait states, requester aborts (e.g. halt dropping strobes mid-access) and a RAM-timeout error.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- TIMEOUT, 255, max cycles an access may wait for ram_ready before error; counter width = clog2(TIMEOUT+1).

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  1  instruction read request (level, held until iHit).
- iaddr  in  ADDR_W  instruction address.
- iload  out  DATA_W  fetched instruction, valid while iHit=1.
- iHit  out  1  one-cycle completion pulse for the instruction access.
- dREN  in  1  data read request (level).
- dWEN  in  1  data write request (level).
- daddr  in  ADDR_W  data address.
- dstore  in  DATA_W  write data.
- dload  out  DATA_W  read data, valid while dHit=1.
- dHit  out  1  one-cycle completion pulse for the data access.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  DATA_W  RAM write data.
- ramload  in  DATA_W  RAM read data, valid when ram_ready=1.
- ram_ready  in  1  RAM completion, one-cycle pulse.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky RAM-timeout flag.

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0: iHit, dHit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, busy, timeout_err.
  - Wait counter=0.
  - Reset asserted mid-access drops ram enables immediately (asynchronous); the RAM access is abandoned.
- States: IDLE, DACC, IACC, DRAIN, RESP.
- IDLE:
  - dREN|dWEN -> DACC.
  - else iREN -> IACC.
  - Data has strict priority over instruction.
  - On the transition, latch address, op and dstore into internal registers; latched values drive ramaddr/ramstore for the whole access.
  - dWEN and dREN both high -> treated as a write only.
- DACC:
  - ramWEN=1 for a write, else ramREN=1.
  - On ram_ready: for a read, register ramload into dload; -> RESP with dHit=1.
  - If dREN=dWEN=0 before ram_ready (abort) -> DRAIN.
- IACC:
  - ramREN=1.
  - On ram_ready: register ramload into iload; -> RESP with iHit=1.
  - If iREN=0 before ram_ready -> DRAIN.
- Abort and ram_ready in the same cycle: the access completes normally (RESP, hit pulsed).
- DRAIN:
  - RAM strobes and latched address/data held until ram_ready; the RAM access cannot be cancelled.
  - On ram_ready -> IDLE; no hit pulse; iload/dload unchanged.
- RESP:
  - Exactly one cycle; hit pulse high, load data valid.
  - Request inputs ignored, because the requester is still sampling the hit and its strobes are still high.
  - ram enables 0. Always -> IDLE next cycle.
- Latency:
  - Request first high in cycle 0 (state IDLE).
  - RAM strobe in cycle 1.
  - ram_ready in cycle k (k>=1) gives hit in cycle k+1.
  - Next request accepted no earlier than cycle k+2.
- dload holds its value on writes and between accesses; iload holds between fetches.
- ram_ready in IDLE or RESP is ignored.
- Timeout:
  - Wait counter clears on entering DACC/IACC and increments each cycle in DACC, IACC or DRAIN without ram_ready.
  - On reaching TIMEOUT: set timeout_err (sticky until reset), drop ram enables, -> IDLE, no hit pulse.
  - Subsequent requests are still served normally.
- busy = (state != IDLE), registered.

Test Plan:
- Data read: dREN=1, daddr=0x40, RAM returns 0xDEADBEEF with ram_ready in cycle 3 -> ramREN=1, ramaddr=0x40 cycles 1-3; dHit=1, dload=0xDEADBEEF in cycle 4 only; IDLE cycle 5.
- Simultaneous: iREN=1 (iaddr=0x0) and dWEN=1 (daddr=0x80, dstore=0x1234) in cycle 0, ram_ready after 1 cycle each time -> write to 0x80 first (ramWEN=1, ramstore=0x1234); dHit pulse; then the instruction read of 0x0; iHit pulse; no dHit/iHit overlap.
- Hit-hold: requester keeps dREN=1 during the RESP cycle -> no second RAM access is started from RESP; a new access starts only if dREN is still high in the following IDLE cycle.
- Abort: iREN=1, then iREN=0 in cycle 2, ram_ready in cycle 4 -> ramREN held cycles 1-4; iHit never asserted; iload unchanged; IDLE in cycle 5.
- Timeout: TIMEOUT=8, dREN=1, no ram_ready -> enables drop after 8 wait cycles; timeout_err=1 and stays 1; a following read with a normal ram_ready still produces dHit.
- Reset mid-access: nRST low while in DACC -> ramREN/ramWEN/busy 0 immediately; after release, state IDLE, timeout_err=0, iHit=dHit=0.
